// File: rtl/move_scan_ctrl_if.sv
// Checker bus between move_scan_ctrl and the shared per-square move checker.
//   chk_x, chk_y       : square coordinates under test (column, row)
//   chk_player_black   : player the move is checked for
//   chk_board          : 64 cells x 2 bits (00 empty, 01 black, 10 white, 11 occupied)
//   chk_valids         : checker result, one valid bit per direction
// master = scan sequencer (drives the square and board), slave = checker.
interface move_scan_ctrl_if;
  logic [2:0]   chk_x;
  logic [2:0]   chk_y;
  logic         chk_player_black;
  logic [127:0] chk_board;
  logic [7:0]   chk_valids;

  modport master (
    output chk_x,
    output chk_y,
    output chk_player_black,
    output chk_board,
    input  chk_valids
  );

  modport slave (
    input  chk_x,
    input  chk_y,
    input  chk_player_black,
    input  chk_board,
    output chk_valids
  );
endinterface

// File: rtl/move_scan_ctrl.sv
// Legal-move scan sequencer: sweeps all 64 squares through the shared move checker
// and builds the legal-move mask, count and first legal square for one player.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   start, abort     : start a scan (IDLE only) / cancel a scan synchronously
//   player_black_in  : player to scan for, sampled on an accepted start
//   board_in         : board, sampled on an accepted start
//   chk              : checker bus (master side)
//   busy, done       : scan in progress / one-cycle completion pulse
//   legal_mask       : bit i set when square i (= y*8 + x) is legal
//   legal_count      : popcount of legal_mask
//   has_move         : legal_count != 0
//   first_x, first_y : coordinates of the lowest-index legal square
module move_scan_ctrl #(
  parameter int unsigned CHECK_LAT = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 player_black_in,
  input  logic [127:0]         board_in,
  move_scan_ctrl_if.master     chk,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          legal_mask,
  output logic [6:0]           legal_count,
  output logic                 has_move,
  output logic [2:0]           first_x,
  output logic [2:0]           first_y
);

  // Counter holds CHECK_LAT-1 at most.
  localparam int unsigned CntW = (CHECK_LAT > 2) ? $clog2(CHECK_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSample, StFin} state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]  board_q, board_d;
  logic          player_q, player_d;
  logic [63:0]   mask_q, mask_d;
  logic [6:0]    count_q, count_d;
  logic          has_q, has_d;
  logic [2:0]    fx_q, fx_d;
  logic [2:0]    fy_q, fy_d;
  logic          cell_empty;

  assign cell_empty = (board_q[{idx_q, 1'b0} +: 2] == 2'b00);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    board_d  = board_q;
    player_d = player_q;
    mask_d   = mask_q;
    count_d  = count_q;
    has_d    = has_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    if (abort) begin
      // Abort also blocks a coincident start in IDLE.
      state_d = StIdle;
      idx_d   = '0;
      mask_d  = '0;
      count_d = '0;
      has_d   = 1'b0;
      fx_d    = '0;
      fy_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            board_d  = board_in;
            player_d = player_black_in;
            idx_d    = '0;
            mask_d   = '0;
            count_d  = '0;
            has_d    = 1'b0;
            fx_d     = '0;
            fy_d     = '0;
            state_d  = StIssue;
          end
        end
        StIssue: begin
          if (!cell_empty) begin
            // Occupied squares are never legal; skip the checker entirely.
            if (idx_q == 6'd63) state_d = StFin;
            else                idx_d   = idx_q + 6'd1;
          end else begin
            cnt_d = CntW'(CHECK_LAT - 1);
            if (CHECK_LAT > 1) state_d = StWait;
            else               state_d = StSample;
          end
        end
        StWait: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StSample;
        end
        StSample: begin
          if (|chk.chk_valids) begin
            mask_d[idx_q] = 1'b1;
            count_d       = count_q + 7'd1;
            has_d         = 1'b1;
            if (!has_q) begin
              fx_d = idx_q[2:0];
              fy_d = idx_q[5:3];
            end
          end
          if (idx_q == 6'd63) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = StIssue;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      board_q  <= '0;
      player_q <= 1'b0;
      mask_q   <= '0;
      count_q  <= '0;
      has_q    <= 1'b0;
      fx_q     <= '0;
      fy_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      board_q  <= board_d;
      player_q <= player_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      has_q    <= has_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
    end
  end

  // idx only moves on square transitions, so the checker inputs stay stable
  // from ISSUE through SAMPLE and hold their last value while idle.
  assign chk.chk_x            = idx_q[2:0];
  assign chk.chk_y            = idx_q[5:3];
  assign chk.chk_player_black = player_q;
  assign chk.chk_board        = board_q;

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);
  assign legal_mask  = mask_q;
  assign legal_count = count_q;
  assign has_move    = has_q;
  assign first_x     = fx_q;
  assign first_y     = fy_q;

endmodule

// File: tb/tb_move_scan_ctrl.sv
// Directed bench: two instances (CHECK_LAT = 2 and 1) share stimulus; each has a
// checker stub delaying its answer by exactly CHECK_LAT cycles.
module tb_move_scan_ctrl;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         player = 1'b0;
  logic [127:0] board = '0;
  logic [63:0]  legal_set = '0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  move_scan_ctrl_if bus2 ();
  move_scan_ctrl_if bus1 ();

  logic        busy2, done2, has2, busy1, done1, has1;
  logic [63:0] mask2, mask1;
  logic [6:0]  count2, count1;
  logic [2:0]  fx2, fy2, fx1, fy1;

  move_scan_ctrl #(.CHECK_LAT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .player_black_in(player), .board_in(board), .chk(bus2.master),
    .busy(busy2), .done(done2), .legal_mask(mask2), .legal_count(count2),
    .has_move(has2), .first_x(fx2), .first_y(fy2)
  );

  move_scan_ctrl #(.CHECK_LAT(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .player_black_in(player), .board_in(board), .chk(bus1.master),
    .busy(busy1), .done(done1), .legal_mask(mask1), .legal_count(count1),
    .has_move(has1), .first_x(fx1), .first_y(fy1)
  );

  function automatic logic [7:0] stub(input logic [2:0] x, input logic [2:0] y);
    logic [5:0] i;
    i = {y, x};
    return legal_set[i] ? 8'h80 : 8'h00;
  endfunction

  logic [7:0] p2a = '0, p2b = '0, p1a = '0;
  always_ff @(posedge clk) begin
    p2a <= stub(bus2.chk_x, bus2.chk_y);
    p2b <= p2a;
    p1a <= stub(bus1.chk_x, bus1.chk_y);
  end
  assign bus2.chk_valids = p2b;
  assign bus1.chk_valids = p1a;

  logic [2:0] xs1 [0:80];
  logic [2:0] ys1 [0:80];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the start edge (cycle 1).
  task automatic start_scan(input logic [127:0] b, input logic p, input logic [63:0] l);
    board = b;
    player = p;
    legal_set = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle k = 1 is the current cycle; returns in the later of the two done cycles.
  task automatic wait_done(output int d2, output int d1);
    d2 = 0;
    d1 = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k <= 80) begin
        xs1[k] = bus1.chk_x;
        ys1[k] = bus1.chk_y;
      end
      if (done2 && d2 == 0) d2 = k;
      if (done1 && d1 == 0) d1 = k;
      if (d2 != 0 && d1 != 0) break;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [127:0] opening_board();
    logic [127:0] b;
    b = '0;
    b[2*27 +: 2] = 2'b10;
    b[2*36 +: 2] = 2'b10;
    b[2*28 +: 2] = 2'b01;
    b[2*35 +: 2] = 2'b01;
    return b;
  endfunction

  function automatic logic [63:0] opening_legal();
    logic [63:0] l;
    l = '0;
    l[19] = 1'b1;
    l[26] = 1'b1;
    l[37] = 1'b1;
    l[44] = 1'b1;
    return l;
  endfunction

  task automatic check_opening(input string tag);
    check_val({tag, "_mask2"}, mask2, opening_legal());
    check_val({tag, "_count2"}, count2, 7'd4);
    check_val({tag, "_has2"}, has2, 1'b1);
    check_val({tag, "_first2"}, {fx2, fy2}, {3'd3, 3'd2});
    check_val({tag, "_mask1"}, mask1, opening_legal());
    check_val({tag, "_count1"}, count1, 7'd4);
  endtask

  logic [127:0] full_board;
  logic [127:0] one_empty;
  int d2, d1;

  initial begin
    full_board = {64{2'b01}};
    one_empty  = full_board;
    one_empty[127:126] = 2'b00;

    // Reset values
    #12;
    check_val("rst_busy", busy2, 1'b0);
    check_val("rst_done", done2, 1'b0);
    check_val("rst_res", {mask2, count2, has2, fx2, fy2}, '0);
    check_val("rst_chk", {bus2.chk_x, bus2.chk_y, bus2.chk_player_black, bus2.chk_board}, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a scan
    start_scan('0, 1'b1, '1);
    repeat (9) @(posedge clk); #1;
    check_val("pre_rst_count2", count2, 7'd3);
    #2 resetn = 1'b0;
    #1;
    check_val("mid_rst_busy", {busy2, busy1}, 2'b00);
    check_val("mid_rst_res", {mask2, count2, has2, mask1, count1}, '0);
    check_val("mid_rst_chk", {bus2.chk_x, bus2.chk_y, bus2.chk_player_black}, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Opening board, black to move
    start_scan(opening_board(), 1'b1, opening_legal());
    check_val("fresh_xy", {bus2.chk_x, bus2.chk_y}, 6'd0);
    check_val("fresh_busy", busy2, 1'b1);
    check_val("open_player", bus2.chk_player_black, 1'b1);
    wait_done(d2, d1);
    check_val("open_done2_cyc", d2, 185);
    check_val("open_done1_cyc", d1, 125);
    check_opening("open");
    @(posedge clk); #1;
    check_val("open_busy_fall", busy2, 1'b0);

    // start while busy is ignored; then back-to-back scans
    start_scan(opening_board(), 1'b1, opening_legal());
    repeat (4) @(posedge clk); #1;
    board = full_board;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_start_board", bus2.chk_board, opening_board());
    wait_done(d2, d1);
    check_val("busy_start_cyc2", d2, 180);
    check_opening("busy_start");
    @(posedge clk); #1;
    start_scan(opening_board(), 1'b1, opening_legal());
    wait_done(d2, d1);
    check_val("b2b_cyc2", d2, 185);
    check_opening("b2b");
    @(posedge clk); #1;

    // Full board, white: no checker waits at all
    start_scan(full_board, 1'b0, '1);
    wait_done(d2, d1);
    check_val("full_cyc2", d2, 65);
    check_val("full_cyc1", d1, 65);
    check_val("full_res2", {mask2, count2, has2, fx2, fy2}, '0);
    check_val("full_player", bus2.chk_player_black, 1'b0);
    @(posedge clk); #1;

    // Single empty square 63
    start_scan(one_empty, 1'b1, 64'h8000_0000_0000_0000);
    wait_done(d2, d1);
    check_val("one_cyc1", d1, 66);
    check_val("one_cyc2", d2, 67);
    check_val("one_mask1", mask1, 64'h8000_0000_0000_0000);
    check_val("one_count1", count1, 7'd1);
    check_val("one_first1", {fx1, fy1, has1}, {3'd7, 3'd7, 1'b1});
    check_val("one_xy_issue", {xs1[64], ys1[64]}, {3'd7, 3'd7});
    check_val("one_xy_sample", {xs1[65], ys1[65]}, {3'd7, 3'd7});
    check_val("one_xy_fin", {xs1[66], ys1[66]}, {3'd7, 3'd7});
    check_val("one_mask2", mask2, 64'h8000_0000_0000_0000);
    @(posedge clk); #1;

    // Abort at cycle 10
    start_scan('0, 1'b1, '1);
    repeat (9) @(posedge clk); #1;
    check_val("pre_abort_count2", count2, 7'd3);
    check_val("pre_abort_count1", count1, 7'd4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort_busy", {busy2, busy1}, 2'b00);
    check_val("abort_res", {mask2, count2, has2, fx2, fy2, mask1, count1}, '0);
    check_val("abort_xy", {bus2.chk_x, bus2.chk_y}, 6'd0);
    d2 = 0;
    for (int k = 0; k < 5; k++) begin
      if (done2 || done1) d2 = 1;
      @(posedge clk); #1;
    end
    check_val("abort_no_done", d2, 0);

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_val("start_abort_busy", {busy2, busy1}, 2'b00);
    @(posedge clk); #1;
    check_val("start_abort_busy_later", busy2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/move_scan_ctrl.md
# move_scan_ctrl

Sequencer that sweeps all 64 board squares through the shared per-square move checker and builds the legal-move mask for one player. It sits between the game FSM and the checker. The game FSM uses its results for pass detection, game-over detection and move hinting. It owns the checker's x/y/player/board inputs while busy. It issues one square at a time and collects the checker's 8 direction-valid bits.

## Interface
Parameters:
- CHECK_LAT, 2, cycles from checker inputs being stable to `chk_valids` being valid; legal range is 1 or more.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a scan; accepted only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE with no `done`
- player_black_in  in  1  player to scan for; sampled on start
- board_in  in  128  board; sampled on start
- chk_x  out  3  checker column
- chk_y  out  3  checker row
- chk_player_black  out  1  latched player
- chk_board  out  128  latched board
- chk_valids  in  8  checker direction-valid bits
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when a scan completes
- legal_mask  out  64  bit i set when square i is a legal move
- legal_count  out  7  number of set bits in legal_mask, 0..64
- has_move  out  1  legal_count != 0
- first_x, first_y  out  3 each  coordinates of the lowest-index legal square

## Operation
- Square index i = y*8 + x, with x = i[2:0] and y = i[5:3].
- Cell i occupies board bits [2i+1:2i]:
  - 00 = empty
  - 01 = black
  - 10 = white
  - 11 = treated as occupied
- States are IDLE, ISSUE, WAIT, SAMPLE and FIN.
- IDLE:
  - On `start` (and no `abort`), latch `board_in` and `player_black_in`.
  - Clear legal_mask, legal_count, has_move, first_x and first_y.
  - Set idx = 0, go to ISSUE.
  - `start` in any other state is ignored.
- ISSUE:
  - Drive chk_x/chk_y from idx.
  - If the cell is occupied: mask bit stays 0, no checker wait. If idx == 63 go to FIN, else increment idx and stay in ISSUE.
  - If the cell is empty: load wait counter with CHECK_LAT-1. Go to WAIT if CHECK_LAT > 1, else go to SAMPLE.
- WAIT: decrement the counter; go to SAMPLE when it reaches 0.
- SAMPLE:
  - legal_mask[idx] = |chk_valids.
  - If the bit is set: increment legal_count and set has_move. If this is the first legal square, capture first_x/first_y.
  - If idx == 63 go to FIN, else increment idx and go to ISSUE.
- FIN: assert `done` for exactly one cycle, go to IDLE.
- chk_x, chk_y, chk_board and chk_player_black hold stable from ISSUE through SAMPLE of each square.
- Outside a scan, these checker outputs hold their last values.
- `abort` in any non-IDLE state:
  - Next state is IDLE, `done` is not pulsed.
  - Results are cleared to 0.
  - chk_x/chk_y return to 0.
- `abort` together with `start` in IDLE: abort wins and the start is dropped.
- Results are held after FIN until the next accepted start or abort. They are meaningful only while busy = 0.
- If no square is legal: first_x = first_y = 0 and has_move = 0.
- legal_count is 7 bits and cannot overflow, since the maximum is 60 for any legal board and 64 theoretically.

## Timing
- Reset (asynchronous, resetn = 0):
  - State goes to IDLE.
  - busy, done, legal_mask, legal_count, has_move, first_x, first_y, chk_x, chk_y, chk_player_black and chk_board are all 0.
  - Reset mid-scan discards all progress.
- busy is high in ISSUE, WAIT, SAMPLE and FIN, and low in IDLE.
- Start accepted on edge 0: the first ISSUE is cycle 1.
- Per-square cost: occupied = 1 cycle; empty = CHECK_LAT+1 cycles (ISSUE, CHECK_LAT-1 WAIT cycles, SAMPLE).
- `done` is high during cycle 1 + N_occ + N_empty*(CHECK_LAT+1).
- busy falls on the following edge.
- `start` can be accepted in the cycle after FIN, so back-to-back scans are permitted.
- legal_mask/legal_count are updated on the SAMPLE edge. Final values are visible in the `done` cycle.

## Test plan
- Reset: assert resetn = 0 mid-scan -> all outputs 0 immediately and state is IDLE. After release, `start` begins a fresh scan from idx 0.
- Opening board, CHECK_LAT = 2, player black, checker stub returning nonzero only for idx 19, 26, 37, 44:
  - `done` at cycle 185 (1 + 4 + 60*3).
  - legal_mask bits 19/26/37/44 set, legal_count = 4, has_move = 1.
  - first_x = 3, first_y = 2.
- Full board (all cells 01), CHECK_LAT = 2:
  - No empty square is issued for a checker wait.
  - `done` at cycle 65, legal_count = 0, has_move = 0, first = (0,0).
- Single empty square idx 63, stub returns 8'h80, CHECK_LAT = 1:
  - `done` at cycle 1 + 63 + 2 = 66.
  - legal_mask = 1<<63, legal_count = 1, first = (7,7).
  - chk_x/chk_y stay at 7/7 from ISSUE through SAMPLE.
- Abort at cycle 10 of a scan -> IDLE next cycle, no `done`, results 0. `start` together with `abort` in IDLE -> busy stays 0.
- `start` pulsed while busy -> ignored and latched board unchanged. `start` in the cycle after `done` -> second scan runs and gives identical results for an identical board.
